// File: rtl/joy_serial_pkg.sv
// joy_serial_pkg: shared types and sizing helpers for the serial joystick receiver.
//   joy_state_e    frame sequencer states
//   SYNC_STAGES    depth of the joy_data synchroniser
//   joy_total      total serial bits in one frame
//   joy_cnt_width  counter width for a 0..n-1 range (never below 1)
package joy_serial_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        StGap,
        StLoad,
        StSettle,
        StLow,
        StHigh,
        StUpdate
    } joy_state_e;

    function automatic int unsigned joy_total(input int unsigned n_players,
                                              input int unsigned bits_per_player);
        return n_players * bits_per_player;
    endfunction

    function automatic int unsigned joy_cnt_width(input int unsigned range_n);
        return (range_n > 1) ? $clog2(range_n) : 1;
    endfunction

endpackage

// File: rtl/joy_serial_rx_if.sv
// joy_serial_rx_if: pins of a 74HC165-style shift-register chain.
//   joy_clk   shift clock to the chain, idle high
//   joy_load  parallel-load strobe, active low, idle high
//   joy_data  serial data coming back from the chain
// master: the receiver that drives the chain; slave: the chain itself.
interface joy_serial_rx_if;

    logic joy_clk;
    logic joy_load;
    logic joy_data;

    modport master (
        output joy_clk,
        output joy_load,
        input  joy_data
    );

    modport slave (
        input  joy_clk,
        input  joy_load,
        output joy_data
    );

endinterface

// File: rtl/joy_tick_gen.sv
// joy_tick_gen: divides clk by CLK_DIV into a one-cycle tick.
//   clk    system clock
//   reset  synchronous, active-high; restarts the divider
//   clear  synchronous restart of the divider (no tick while asserted)
//   tick   one-cycle pulse on the last cycle of every CLK_DIV-cycle period
module joy_tick_gen
    import joy_serial_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CntW = joy_cnt_width(CLK_DIV);
    localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || (cnt_q == CntLast)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CntLast) && !clear;

endmodule

// File: rtl/joy_serial_rx.sv
// joy_serial_rx: scans a chain of parallel-in/serial-out shift registers and
// presents the decoded buttons of every player.
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       scan enable, only looked at between frames
//   chain        joy_serial_rx_if.master: joy_clk / joy_load out, joy_data in
//   joystick     player p at [p*BITS_PER_PLAYER +: BITS_PER_PLAYER], serial bit i -> bit i
//   frame_valid  one-cycle pulse whenever joystick is loaded from a frame
// Optional: define JOY_SERIAL_DEBOUNCE_EN to publish a frame only when it matches
// the previous raw frame.
// joy_data passes a 2-flop synchroniser, so CLK_DIV must be at least 3.
module joy_serial_rx
    import joy_serial_pkg::*;
#(
    parameter int unsigned N_PLAYERS       = 2,
    parameter int unsigned BITS_PER_PLAYER = 12,
    parameter int unsigned CLK_DIV         = 4,
    parameter int unsigned FRAME_GAP       = 8,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  enable,
    joy_serial_rx_if.master                       chain,
    output logic [N_PLAYERS*BITS_PER_PLAYER-1:0]  joystick,
    output logic                                  frame_valid
);

    localparam int unsigned TOTAL = joy_total(N_PLAYERS, BITS_PER_PLAYER);
    localparam int unsigned BitW  = joy_cnt_width(TOTAL);
    localparam int unsigned GapW  = joy_cnt_width(FRAME_GAP);
    localparam logic [BitW-1:0] LastBit = BitW'(TOTAL - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(FRAME_GAP - 1);

    joy_state_e             state_q, state_d;
    logic [GapW-1:0]        gap_q, gap_d;
    logic [BitW-1:0]        bit_q, bit_d;
    logic [TOTAL-1:0]       shift_q, shift_d;
    logic [TOTAL-1:0]       joystick_q, joystick_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   joy_clk_q, joy_clk_d;
    logic                   joy_load_q, joy_load_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [TOTAL-1:0]       cooked;
    logic                   sample;
    logic                   tick;

`ifdef JOY_SERIAL_DEBOUNCE_EN
    logic [TOTAL-1:0]       prev_q, prev_d;
    logic                   prev_valid_q, prev_valid_d;
`endif

    joy_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .clear(state_q == StUpdate),
        .tick (tick)
    );

    // The sample point is the last cycle of a tick, so the 2-cycle synchroniser
    // lag still lands inside the state that presented the bit.
    assign sample = sync_q[SYNC_STAGES-1];
    assign cooked = ACTIVE_LOW ? ~shift_q : shift_q;

    always_comb begin
        state_d       = state_q;
        gap_d         = gap_q;
        bit_d         = bit_q;
        shift_d       = shift_q;
        joystick_d    = joystick_q;
        frame_valid_d = 1'b0;
`ifdef JOY_SERIAL_DEBOUNCE_EN
        prev_d        = prev_q;
        prev_valid_d  = prev_valid_q;
`endif
        unique case (state_q)
            StGap: begin
                if (!enable) begin
                    joystick_d = '0;
                end
                if (tick) begin
                    // Gap counter saturates until enable lets the next frame start.
                    if (gap_q == GapLast) begin
                        if (enable) begin
                            state_d = StLoad;
                            gap_d   = '0;
                        end
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
            StLoad: begin
                if (tick) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (tick) begin
                    shift_d[0] = sample;
                    bit_d      = BitW'(1);
                    state_d    = StLow;
                end
            end
            StLow: begin
                if (tick) begin
                    state_d = StHigh;
                end
            end
            StHigh: begin
                if (tick) begin
                    shift_d[bit_q] = sample;
                    bit_d          = bit_q + 1'b1;
                    state_d        = (bit_q == LastBit) ? StUpdate : StLow;
                end
            end
            StUpdate: begin
`ifdef JOY_SERIAL_DEBOUNCE_EN
                if (prev_valid_q && (shift_q == prev_q)) begin
                    joystick_d    = cooked;
                    frame_valid_d = 1'b1;
                end
                prev_d       = shift_q;
                prev_valid_d = 1'b1;
`else
                joystick_d    = cooked;
                frame_valid_d = 1'b1;
`endif
                bit_d   = '0;
                state_d = StGap;
            end
            default: begin
                state_d = StGap;
            end
        endcase
        // Pin levels are registered from the next state so they change cleanly.
        joy_clk_d  = (state_d != StLow);
        joy_load_d = (state_d != StLoad);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StGap;
            gap_q         <= '0;
            bit_q         <= '0;
            shift_q       <= '0;
            joystick_q    <= '0;
            frame_valid_q <= 1'b0;
            joy_clk_q     <= 1'b1;
            joy_load_q    <= 1'b1;
            sync_q        <= '0;
        end else begin
            state_q       <= state_d;
            gap_q         <= gap_d;
            bit_q         <= bit_d;
            shift_q       <= shift_d;
            joystick_q    <= joystick_d;
            frame_valid_q <= frame_valid_d;
            joy_clk_q     <= joy_clk_d;
            joy_load_q    <= joy_load_d;
            sync_q        <= {sync_q[SYNC_STAGES-2:0], chain.joy_data};
        end
    end

`ifdef JOY_SERIAL_DEBOUNCE_EN
    // All-ones with the valid flag clear: the first frame after reset never publishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q       <= '1;
            prev_valid_q <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
        end
    end
`endif

    assign joystick       = joystick_q;
    assign frame_valid    = frame_valid_q;
    assign chain.joy_clk  = joy_clk_q;
    assign chain.joy_load = joy_load_q;

endmodule
